// File: rtl/ddr3_sched_pkg.sv
// Shared state encodings and frame-size default for the DDR3 burst scheduler.
package ddr3_sched_pkg;

    typedef logic [2:0] sched_state_t;

    localparam sched_state_t ST_IDLE    = 3'd0;
    localparam sched_state_t ST_WR_REQ  = 3'd1;
    localparam sched_state_t ST_WR_WAIT = 3'd2;
    localparam sched_state_t ST_RD_REQ  = 3'd3;
    localparam sched_state_t ST_RD_WAIT = 3'd4;

    // 1920*1080 pixels * 2 bytes / 256 bytes per burst
    localparam int FRAME_BURSTS_DEF = 16200;

endpackage

// File: rtl/sched_rr_arb.sv
// Two-way round-robin arbiter between write and read bursts; remembers the
// direction served last and favours the other one when both are requesting.
module sched_rr_arb (
    input  logic ui_clk,
    input  logic Rst_INIT_DONE,
    input  logic grant_en_i,
    input  logic req_wr_i,
    input  logic req_rd_i,
    output logic grant_wr_o,
    output logic grant_rd_o
);

    // 1 = write was served last; reset value is read so write wins first
    logic last_wr_q, last_wr_d;

    always_comb begin
        grant_wr_o = 1'b0;
        grant_rd_o = 1'b0;
        if (grant_en_i) begin
            if (req_wr_i && req_rd_i) begin
                grant_wr_o = !last_wr_q;
                grant_rd_o = last_wr_q;
            end else begin
                grant_wr_o = req_wr_i;
                grant_rd_o = req_rd_i;
            end
        end
        last_wr_d = last_wr_q;
        if (grant_wr_o)      last_wr_d = 1'b1;
        else if (grant_rd_o) last_wr_d = 1'b0;
    end

    always_ff @(posedge ui_clk or negedge Rst_INIT_DONE) begin
        if (!Rst_INIT_DONE) last_wr_q <= 1'b0;
        else                last_wr_q <= last_wr_d;
    end

endmodule

// File: rtl/ddr3_burst_scheduler.sv
// Schedules one outstanding AXI write or read burst at a time between the video FIFOs and DDR3.
// Define SCHED_WDOG_EN to add a per-burst timeout that raises wdog_err and abandons the burst.
//
//  state    | meaning
//  IDLE     | choose next burst direction (at least one cycle between bursts)
//  WR_REQ   | one-cycle Aw_Wr_trigger
//  WR_WAIT  | wait for wr_done (B handshake)
//  RD_REQ   | one-cycle R_Rd_trigger
//  RD_WAIT  | wait for rd_done (last R beat)
module ddr3_burst_scheduler
    import ddr3_sched_pkg::*;
#(
    parameter int BURST_BEATS  = 16,
    parameter int FIFO_DEPTH   = 512,
    parameter int CNT_W        = 10,
    parameter int FRAME_BURSTS = FRAME_BURSTS_DEF,
    parameter int WDOG_CYCLES  = 4096
) (
    input  logic             ui_clk,
    input  logic             Rst_INIT_DONE,
    input  logic             wr_enable,
    input  logic             rd_enable,
    input  logic [CNT_W-1:0] wfifo_rd_count,
    input  logic [CNT_W-1:0] rfifo_wr_count,
    input  logic             wr_done,
    input  logic             rd_done,
    output logic             Aw_Wr_trigger,
    output logic             R_Rd_trigger,
    output logic             wr_frame_done,
    output logic             rd_frame_done,
    output logic [2:0]       sched_state,
    output logic             wdog_err
);

    localparam int                BC_W    = $clog2(FRAME_BURSTS);
    localparam logic [BC_W-1:0]   BC_LAST = BC_W'(FRAME_BURSTS - 1);
    localparam logic [CNT_W:0]    BEATS_C = (CNT_W + 1)'(BURST_BEATS);
    localparam logic [CNT_W:0]    DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    if (WDOG_CYCLES < 2 || BURST_BEATS > FIFO_DEPTH) begin : g_bad_param
        $error("ddr3_burst_scheduler: invalid WDOG_CYCLES or BURST_BEATS");
    end

    sched_state_t    state_q, state_d;
    logic [BC_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic            aw_trig_q, aw_trig_d, r_trig_q, r_trig_d;
    logic            wr_fd_q, wr_fd_d, rd_fd_q, rd_fd_d;
    logic            wr_ok, rd_ok, grant_wr, grant_rd;
    logic [CNT_W:0]  rd_used, rd_free;

    // an over-reported read count is treated as a full FIFO rather than wrapping
    assign rd_used = {1'b0, rfifo_wr_count};
    assign rd_free = (rd_used > DEPTH_C) ? '0 : DEPTH_C - rd_used;
    assign wr_ok   = wr_enable && ({1'b0, wfifo_rd_count} >= BEATS_C);
    assign rd_ok   = rd_enable && (rd_free >= BEATS_C);

    sched_rr_arb u_arb (
        .ui_clk        (ui_clk),
        .Rst_INIT_DONE (Rst_INIT_DONE),
        .grant_en_i    (state_q == ST_IDLE),
        .req_wr_i      (wr_ok),
        .req_rd_i      (rd_ok),
        .grant_wr_o    (grant_wr),
        .grant_rd_o    (grant_rd)
    );

`ifdef SCHED_WDOG_EN
    localparam int              WD_W    = $clog2(WDOG_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            wdog_err_q, wdog_err_d;
`endif

    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        wr_fd_d  = 1'b0;
        rd_fd_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_wr)      state_d = ST_WR_REQ;
                else if (grant_rd) state_d = ST_RD_REQ;
            end
            ST_WR_REQ: state_d = ST_WR_WAIT;
            ST_RD_REQ: state_d = ST_RD_WAIT;
            ST_WR_WAIT: begin
                if (wr_done) begin
                    state_d  = ST_IDLE;
                    wr_fd_d  = (wr_cnt_q == BC_LAST);
                    wr_cnt_d = wr_fd_d ? '0 : wr_cnt_q + 1'b1;
                end
            end
            ST_RD_WAIT: begin
                if (rd_done) begin
                    state_d  = ST_IDLE;
                    rd_fd_d  = (rd_cnt_q == BC_LAST);
                    rd_cnt_d = rd_fd_d ? '0 : rd_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef SCHED_WDOG_EN
        wdog_d     = '0;
        wdog_err_d = 1'b0;
        // a done arriving on the timeout cycle still completes the burst
        if ((state_q == ST_WR_WAIT && !wr_done) || (state_q == ST_RD_WAIT && !rd_done)) begin
            if (wdog_q == WD_LAST) begin
                state_d    = ST_IDLE;
                wdog_err_d = 1'b1;
            end else begin
                wdog_d = wdog_q + 1'b1;
            end
        end
`endif
        aw_trig_d = (state_d == ST_WR_REQ);
        r_trig_d  = (state_d == ST_RD_REQ);
    end

    always_ff @(posedge ui_clk or negedge Rst_INIT_DONE) begin
        if (!Rst_INIT_DONE) begin
            state_q   <= ST_IDLE;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            aw_trig_q <= 1'b0;
            r_trig_q  <= 1'b0;
            wr_fd_q   <= 1'b0;
            rd_fd_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            aw_trig_q <= aw_trig_d;
            r_trig_q  <= r_trig_d;
            wr_fd_q   <= wr_fd_d;
            rd_fd_q   <= rd_fd_d;
        end
    end

`ifdef SCHED_WDOG_EN
    always_ff @(posedge ui_clk or negedge Rst_INIT_DONE) begin
        if (!Rst_INIT_DONE) begin
            wdog_q     <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_q     <= wdog_d;
            wdog_err_q <= wdog_err_d;
        end
    end
    assign wdog_err = wdog_err_q;
`else
    assign wdog_err = 1'b0;
`endif

    assign Aw_Wr_trigger = aw_trig_q;
    assign R_Rd_trigger  = r_trig_q;
    assign wr_frame_done = wr_fd_q;
    assign rd_frame_done = rd_fd_q;
    assign sched_state   = state_q;

endmodule

// File: tb/tb_ddr3_burst_scheduler.sv
// Scoreboard bench for ddr3_burst_scheduler: expected trigger directions are queued
// as stimulus is driven and popped by a monitor whenever a trigger appears.
module tb_ddr3_burst_scheduler;

    logic       ui_clk = 1'b0;
    logic       Rst_INIT_DONE = 1'b0;
    logic       wr_enable = 1'b0, rd_enable = 1'b0;
    logic [9:0] wfifo_rd_count = '0, rfifo_wr_count = '0;
    logic       wr_done = 1'b0, rd_done = 1'b0;
    logic       Aw_Wr_trigger, R_Rd_trigger, wr_frame_done, rd_frame_done, wdog_err;
    logic [2:0] sched_state;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [1:0] exp_q[$];

    localparam logic [1:0] DIR_W = 2'b10;
    localparam logic [1:0] DIR_R = 2'b01;

    always #5 ui_clk = ~ui_clk;

    ddr3_burst_scheduler dut (
        .ui_clk         (ui_clk),
        .Rst_INIT_DONE  (Rst_INIT_DONE),
        .wr_enable      (wr_enable),
        .rd_enable      (rd_enable),
        .wfifo_rd_count (wfifo_rd_count),
        .rfifo_wr_count (rfifo_wr_count),
        .wr_done        (wr_done),
        .rd_done        (rd_done),
        .Aw_Wr_trigger  (Aw_Wr_trigger),
        .R_Rd_trigger   (R_Rd_trigger),
        .wr_frame_done  (wr_frame_done),
        .rd_frame_done  (rd_frame_done),
        .sched_state    (sched_state),
        .wdog_err       (wdog_err)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge ui_clk) begin
        if (Aw_Wr_trigger || R_Rd_trigger) begin
            if (exp_q.size() == 0) check_val("unexpected_trigger", {Aw_Wr_trigger, R_Rd_trigger}, 0);
            else                   check_val("trigger_dir", {Aw_Wr_trigger, R_Rd_trigger}, exp_q.pop_front());
        end
    end

    task automatic do_reset();
        Rst_INIT_DONE = 1'b0;
        wr_enable = 1'b0; rd_enable = 1'b0; wr_done = 1'b0; rd_done = 1'b0;
        repeat (3) @(negedge ui_clk);
        check_val("rst_state", sched_state, 0);
        check_val("rst_outs", {Aw_Wr_trigger, R_Rd_trigger, wr_frame_done, rd_frame_done, wdog_err}, 0);
        Rst_INIT_DONE = 1'b1;
    endtask

    task automatic wait_trig(output int n);
        n = -1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge ui_clk);
            if (Aw_Wr_trigger || R_Rd_trigger) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic pulse_done(input logic is_wr, output logic fd);
        @(negedge ui_clk);
        if (is_wr) wr_done = 1'b1; else rd_done = 1'b1;
        @(negedge ui_clk);
        wr_done = 1'b0; rd_done = 1'b0;
        fd = is_wr ? wr_frame_done : rd_frame_done;
    endtask

    task automatic burst(input logic is_wr, input logic stop, output logic fd);
        int n;
        exp_q.push_back(is_wr ? DIR_W : DIR_R);
        wait_trig(n);
        check_val(is_wr ? "wr_latency" : "rd_latency", n, 1);
        if (stop) begin wr_enable = 1'b0; rd_enable = 1'b0; end
        pulse_done(is_wr, fd);
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   n, fd_count;
        logic fd, seen;

        // single write burst: trigger one cycle after release, then hold until wr_done
        do_reset();
        wr_enable = 1'b1; wfifo_rd_count = 10'd16;
        exp_q.push_back(DIR_W);
        wait_trig(n);
        check_val("first_trig_cycle", n, 1);
        check_val("state_wr_req", sched_state, 1);
        repeat (10) @(negedge ui_clk);
        check_val("state_wr_wait", sched_state, 2);
        pulse_done(1'b1, fd);
        check_val("state_after_done", sched_state, 0);
        exp_q.push_back(DIR_W);
        wait_trig(n);
        check_val("idle_gap", n, 1);
        wr_enable = 1'b0;
        pulse_done(1'b1, fd);

        // write threshold 15 vs 16; read done in WR_WAIT and enable drop do not disturb burst
        wr_enable = 1'b1; wfifo_rd_count = 10'd15;
        repeat (10) @(negedge ui_clk);
        check_val("wr_below_thresh", sched_state, 0);
        wfifo_rd_count = 10'd16;
        exp_q.push_back(DIR_W);
        wait_trig(n);
        check_val("wr_at_thresh", n, 1);
        wr_enable = 1'b0;
        pulse_done(1'b0, fd);
        check_val("rd_done_ignored", sched_state, 2);
        check_val("rd_fd_quiet", fd, 0);
        repeat (3) @(negedge ui_clk);
        check_val("enable_drop_holds", sched_state, 2);
        pulse_done(1'b1, fd);
        check_val("wait_exit", sched_state, 0);
        pulse_done(1'b1, fd);
        check_val("idle_wr_done_ignored", sched_state, 0);
        pulse_done(1'b0, fd);
        check_val("idle_rd_done_ignored", sched_state, 0);

        // read free-space threshold and over-range count
        rd_enable = 1'b1; rfifo_wr_count = 10'd497;
        repeat (10) @(negedge ui_clk);
        check_val("rd_free15", sched_state, 0);
        rfifo_wr_count = 10'd600;
        repeat (5) @(negedge ui_clk);
        check_val("rd_overrange", sched_state, 0);
        rfifo_wr_count = 10'd496;
        burst(1'b0, 1'b1, fd);
        check_val("rd_wait_exit", sched_state, 0);

        // contested grants alternate starting with write
        do_reset();
        wr_enable = 1'b1; rd_enable = 1'b1; wfifo_rd_count = 10'd16; rfifo_wr_count = 10'd0;
        for (int k = 0; k < 4; k++) burst((k % 2) == 0, k == 3, fd);
        repeat (3) @(negedge ui_clk);
        check_val("rr_quiet", sched_state, 0);

        // reset in the middle of WR_WAIT
        wr_enable = 1'b1;
        exp_q.push_back(DIR_W);
        wait_trig(n);
        @(negedge ui_clk);
        check_val("pre_rst_wait", sched_state, 2);
        Rst_INIT_DONE = 1'b0;
        #1;
        check_val("midrst_state", sched_state, 0);
        check_val("midrst_outs", {Aw_Wr_trigger, R_Rd_trigger, wr_frame_done, rd_frame_done, wdog_err}, 0);
        repeat (2) @(negedge ui_clk);
        Rst_INIT_DONE = 1'b1;
        burst(1'b1, 1'b1, fd);

`ifdef SCHED_WDOG_EN
        wr_enable = 1'b1;
        exp_q.push_back(DIR_W);
        wait_trig(n);
        wr_enable = 1'b0;
        n = -1;
        for (int i = 1; i <= 5000; i++) begin
            @(negedge ui_clk);
            if (wdog_err) begin n = i; break; end
        end
        check_val("wdog_cycle", n, 4097);
        check_val("wdog_idle", sched_state, 0);
        @(negedge ui_clk);
        check_val("wdog_one_pulse", wdog_err, 0);
`else
        wr_enable = 1'b1;
        exp_q.push_back(DIR_W);
        wait_trig(n);
        wr_enable = 1'b0;
        seen = 1'b0;
        repeat (4200) begin
            @(negedge ui_clk);
            if (wdog_err) seen = 1'b1;
        end
        check_val("no_wdog_err", seen, 0);
        check_val("no_wdog_wait", sched_state, 2);
        pulse_done(1'b1, fd);
`endif

        // one full frame of write bursts
        do_reset();
        wr_enable = 1'b1; wfifo_rd_count = 10'd16;
        fd_count = 0;
        for (int i = 0; i < 16200; i++) begin
            burst(1'b1, i == 16199, fd);
            check_val("frame_done", fd, (i == 16199) ? 1 : 0);
            if (fd === 1'b1) fd_count++;
        end
        check_val("frame_done_count", fd_count, 1);
        wr_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            burst(1'b1, i == 2, fd);
            check_val("post_wrap_fd", fd, 0);
        end

        repeat (3) @(negedge ui_clk);
        check_val("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
